// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage with IF/ID pipeline register.
// Keeps one request outstanding to a variable-latency instruction memory and
// applies jr/jalr, j/jal and taken-branch redirects resolved in ID.
// Optional build macro FETCH_PERF_CNT_EN adds perf_fetched/perf_squashed counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter int unsigned IMEM_AW  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic               imem_ready,
  input  logic               imem_rvalid,
  input  logic [31:0]        imem_rdata,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic               jump,
  input  logic               r_jump,
  input  logic [31:0]        jr_target,
  output logic               id_valid,
  output logic [31:0]        id_instr,
  output logic [31:0]        id_pc,
  output logic [31:0]        id_pc_plus4,
  output logic [5:0]         id_opcode,
  output logic [5:0]         id_funct,
  output logic [4:0]         id_rt
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_squashed
`endif
);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StHold, StDrop} state_e;

  state_e      r_state, w_state_d;
  logic [31:0] r_pc, w_pc_d;
  logic [31:0] r_hold, w_hold_d;
  logic        r_id_valid;
  logic [31:0] r_id_instr, r_id_pc, r_id_pc4;

  logic        w_redir;
  logic [31:0] w_tgt_raw, w_target, w_br_off;
  logic        w_load, w_squash;
  logic [31:0] w_load_data;

  // Redirect acceptance and target selection (r_jump > jump > branch_taken).
  always_comb begin
    w_redir  = !stall && r_id_valid && (r_jump || jump || branch_taken);
    w_br_off = {{14{r_id_instr[15]}}, r_id_instr[15:0], 2'b00};
    if (r_jump) begin
      w_tgt_raw = jr_target;
    end else if (jump) begin
      w_tgt_raw = {r_id_pc4[31:28], r_id_instr[25:0], 2'b00};
    end else begin
      w_tgt_raw = r_id_pc4 + w_br_off;
    end
    w_target = {w_tgt_raw[31:2], 2'b00};
  end

  // Fetch FSM next-state, PC update and hold-buffer capture.
  always_comb begin
    w_state_d   = r_state;
    w_pc_d      = r_pc;
    w_hold_d    = r_hold;
    w_load      = 1'b0;
    w_load_data = imem_rdata;
    w_squash    = 1'b0;
    case (r_state)
      StIdle: w_state_d = StReq;
      StReq: begin
        // Accepted request whose PC is already stale must be drained.
        if (imem_ready) w_state_d = w_redir ? StDrop : StWait;
      end
      StWait: begin
        if (imem_rvalid) begin
          if (w_redir) begin
            w_squash  = 1'b1;
            w_state_d = StReq;
          end else if (!stall) begin
            w_load    = 1'b1;
            w_pc_d    = r_pc + 32'd4;
            w_state_d = StReq;
          end else begin
            w_hold_d  = imem_rdata;
            w_state_d = StHold;
          end
        end else if (w_redir) begin
          w_state_d = StDrop;
        end
      end
      StHold: begin
        if (w_redir) begin
          w_squash  = 1'b1;
          w_state_d = StReq;
        end else if (!stall) begin
          w_load      = 1'b1;
          w_load_data = r_hold;
          w_pc_d      = r_pc + 32'd4;
          w_state_d   = StReq;
        end
      end
      StDrop: begin
        if (imem_rvalid) begin
          w_squash  = 1'b1;
          w_state_d = StReq;
        end
      end
      default: w_state_d = StIdle;
    endcase
    if (w_redir) w_pc_d = w_target;
  end

  // FSM state, PC and hold buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_pc    <= RESET_PC;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_d;
      r_pc    <= w_pc_d;
      r_hold  <= w_hold_d;
    end
  end

  // IF/ID register: load a word, squash on redirect, bubble once consumed, hold on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id_valid <= 1'b0;
      r_id_instr <= '0;
      r_id_pc    <= '0;
      r_id_pc4   <= '0;
    end else if (w_redir) begin
      r_id_valid <= 1'b0;
    end else if (w_load) begin
      r_id_valid <= 1'b1;
      r_id_instr <= w_load_data;
      r_id_pc    <= r_pc;
      r_id_pc4   <= r_pc + 32'd4;
    end else if (!stall) begin
      r_id_valid <= 1'b0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetched, r_perf_squashed;

  // Count words delivered to ID and words thrown away by redirects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetched  <= '0;
      r_perf_squashed <= '0;
    end else begin
      if (w_load)   r_perf_fetched  <= r_perf_fetched + 32'd1;
      if (w_squash) r_perf_squashed <= r_perf_squashed + 32'd1;
    end
  end

  assign perf_fetched  = r_perf_fetched;
  assign perf_squashed = r_perf_squashed;
`endif

  assign imem_req    = (r_state == StReq);
  assign imem_addr   = r_pc;
  assign id_valid    = r_id_valid;
  assign id_instr    = r_id_valid ? r_id_instr : 32'd0;
  assign id_pc       = r_id_pc;
  assign id_pc_plus4 = r_id_pc4;
  assign id_opcode   = id_instr[31:26];
  assign id_funct    = id_instr[5:0];
  assign id_rt       = id_instr[20:16];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage; the bench itself plays the instruction memory
// and the decode stage cycle by cycle.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic        jump = 1'b0;
  logic        r_jump = 1'b0;
  logic [31:0] jr_target = 32'd0;
  logic        id_valid;
  logic [31:0] id_instr, id_pc, id_pc_plus4;
  logic [5:0]  id_opcode, id_funct;
  logic [4:0]  id_rt;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_squashed;
`endif

  int n_checks = 0;
  int n_errors = 0;

  fetch_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .branch_taken (branch_taken),
    .jump         (jump),
    .r_jump       (r_jump),
    .jr_target    (jr_target),
    .id_valid     (id_valid),
    .id_instr     (id_instr),
    .id_pc        (id_pc),
    .id_pc_plus4  (id_pc_plus4),
    .id_opcode    (id_opcode),
    .id_funct     (id_funct),
    .id_rt        (id_rt)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_squashed(perf_squashed)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request-accept cycle after confirming the expected address.
  task automatic do_req(input string tag, input logic [31:0] addr);
    check({tag, "_req"}, {31'd0, imem_req}, 32'd1);
    check({tag, "_addr"}, imem_addr, addr);
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
  endtask

  // Return one response word.
  task automatic do_rsp(input logic [31:0] data);
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    step();
    imem_rvalid = 1'b0;
  endtask

  initial begin
    // Reset values
    step();
    step();
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, id_valid}, 32'd0);
    check("rst_instr", id_instr, 32'd0);
    check("rst_pc", id_pc, 32'd0);
    check("rst_pc4", id_pc_plus4, 32'd0);
    rst_n = 1'b1;
    step();  // IDLE -> REQ

    // Basic fetch, 2 cycles per instruction
    do_req("f0", 32'h0040_0000);
    do_rsp(32'h8C08_0004);
    check("f0_valid", {31'd0, id_valid}, 32'd1);
    check("f0_instr", id_instr, 32'h8C08_0004);
    check("f0_pc", id_pc, 32'h0040_0000);
    check("f0_pc4", id_pc_plus4, 32'h0040_0004);
    check("f0_opcode", {26'd0, id_opcode}, 32'h23);
    check("f0_rt", {27'd0, id_rt}, 32'd8);
    check("f0_funct", {26'd0, id_funct}, 32'h04);
    do_req("f1", 32'h0040_0004);
    check("f1_bubble", {31'd0, id_valid}, 32'd0);
    check("f1_bubble_instr", id_instr, 32'd0);
    do_rsp(32'h0000_0000);
    check("f1_valid", {31'd0, id_valid}, 32'd1);
    check("f1_pc", id_pc, 32'h0040_0004);

    // j 0x00400040 redirected while REQ is accepted -> DROP
    do_req("j", 32'h0040_0008);
    do_rsp(32'h0810_0010);
    check("j_pc", id_pc, 32'h0040_0008);
    jump = 1'b1;
    imem_ready = 1'b1;
    step();
    jump = 1'b0;
    imem_ready = 1'b0;
    check("j_drop_req", {31'd0, imem_req}, 32'd0);
    check("j_squash_valid", {31'd0, id_valid}, 32'd0);
    check("j_squash_instr", id_instr, 32'd0);
    do_rsp(32'hDEAD_BEEF);
    check("j_late_valid", {31'd0, id_valid}, 32'd0);
    check("j_late_instr", id_instr, 32'd0);

    // jr to 0x00400010 while REQ not accepted
    do_req("jr", 32'h0040_0040);
    do_rsp(32'h03E0_0008);
    r_jump = 1'b1;
    jr_target = 32'h0040_0010;
    step();
    r_jump = 1'b0;
    check("jr_addr", imem_addr, 32'h0040_0010);
    check("jr_valid", {31'd0, id_valid}, 32'd0);

    // Branch imm 0xFFFC at 0x00400010, redirect in WAIT without rvalid
    do_req("br", 32'h0040_0010);
    do_rsp(32'h1000_FFFC);
    check("br_pc", id_pc, 32'h0040_0010);
    stall = 1'b1;
    branch_taken = 1'b1;
    imem_ready = 1'b1;
    step();  // ignored under stall, request accepted -> WAIT
    imem_ready = 1'b0;
    check("br_stall_valid", {31'd0, id_valid}, 32'd1);
    check("br_stall_pc", id_pc, 32'h0040_0010);
    stall = 1'b0;
    step();  // redirect in WAIT -> DROP
    branch_taken = 1'b0;
    check("br_drop_req", {31'd0, imem_req}, 32'd0);
    check("br_drop_valid", {31'd0, id_valid}, 32'd0);
    do_rsp(32'h0000_0BAD);
    check("br_late_valid", {31'd0, id_valid}, 32'd0);

    // Priority: all three redirects, r_jump wins with low bits cleared
    do_req("pri", 32'h0040_0004);
    do_rsp(32'h0810_0010);
    r_jump = 1'b1;
    jump = 1'b1;
    branch_taken = 1'b1;
    jr_target = 32'h0040_0123;
    step();
    r_jump = 1'b0;
    jump = 1'b0;
    branch_taken = 1'b0;
    check("pri_addr", imem_addr, 32'h0040_0120);

    // Stall for 5 cycles while the next word arrives
    do_req("st0", 32'h0040_0120);
    do_rsp(32'h0000_0020);
    check("st0_pc", id_pc, 32'h0040_0120);
    stall = 1'b1;
    do_req("st1", 32'h0040_0124);  // stall cycle 1
    check("st_c1_valid", {31'd0, id_valid}, 32'd1);
    do_rsp(32'h2009_0005);  // stall cycle 2 -> HOLD
    check("st_hold_req", {31'd0, imem_req}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("st_hold_instr", id_instr, 32'h0000_0020);
      check("st_hold_pc", id_pc, 32'h0040_0120);
      step();  // stall cycles 3..5
    end
    stall = 1'b0;
    step();
    check("st_rel_valid", {31'd0, id_valid}, 32'd1);
    check("st_rel_instr", id_instr, 32'h2009_0005);
    check("st_rel_pc", id_pc, 32'h0040_0124);
    check("st_rel_pc4", id_pc_plus4, 32'h0040_0128);
    do_req("st2", 32'h0040_0128);
    check("st_no_dup", {31'd0, id_valid}, 32'd0);

`ifdef FETCH_PERF_CNT_EN
    check("perf_fetched", perf_fetched, 32'd8);
    check("perf_squashed", perf_squashed, 32'd2);
`endif

    // Reset while in WAIT, stray rvalid pulses afterwards
    rst_n = 1'b0;
    #1;
    check("mrst_req", {31'd0, imem_req}, 32'd0);
    check("mrst_valid", {31'd0, id_valid}, 32'd0);
    check("mrst_pc", id_pc, 32'd0);
    check("mrst_pc4", id_pc_plus4, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check("mrst_perf_f", perf_fetched, 32'd0);
    check("mrst_perf_s", perf_squashed, 32'd0);
`endif
    imem_rvalid = 1'b1;
    imem_rdata = 32'hFFFF_FFFF;
    step();
    rst_n = 1'b1;
    step();  // IDLE with stray rvalid
    check("mrst_idle_valid", {31'd0, id_valid}, 32'd0);
    step();  // REQ with stray rvalid, no ready
    imem_rvalid = 1'b0;
    check("mrst_stray_valid", {31'd0, id_valid}, 32'd0);
    do_req("mrst", 32'h0040_0000);
    do_rsp(32'h1111_1111);
    check("mrst_pc_after", id_pc, 32'h0040_0000);
    check("mrst_instr_after", id_instr, 32'h1111_1111);

    // PC wrap at the top of the address space
    r_jump = 1'b1;
    jr_target = 32'hFFFF_FFFE;
    step();
    r_jump = 1'b0;
    do_req("wrap", 32'hFFFF_FFFC);
    do_rsp(32'h0000_0000);
    check("wrap_pc", id_pc, 32'hFFFF_FFFC);
    check("wrap_pc4", id_pc_plus4, 32'd0);
    check("wrap_addr", imem_addr, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the decode/control unit.
- Holds the PC and issues one outstanding request at a time to a variable-latency instruction memory.
- Registers the returned word with its PC and PC+4, and presents the opcode, funct and rt fields to the decoder.
- Applies next-PC redirects decided in ID: conditional branch, j/jal, jr/jalr. No branch delay slot; a redirect squashes the younger fetch.

Parameters:
- RESET_PC, 32'h0040_0000: PC loaded on reset.
- IMEM_AW, 32: instruction address width. Must be 32.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  request valid.
- imem_addr  out  32  word address (byte address, [1:0] always 0).
- imem_ready  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  response word valid.
- imem_rdata  in  32  response instruction.
- stall  in  1  ID cannot accept a new instruction; IF/ID holds.
- branch_taken  in  1  conditional branch in ID resolved taken.
- jump  in  1  j/jal in ID.
- r_jump  in  1  jr/jalr in ID.
- jr_target  in  32  rs value for jr/jalr.
- id_valid  out  1  IF/ID holds a live instruction.
- id_instr  out  32  instruction; forced 0 (nop) when id_valid=0.
- id_pc  out  32  PC of id_instr.
- id_pc_plus4  out  32  id_pc+4, used for the jal/jalr link.
- id_opcode  out  6  id_instr[31:26].
- id_funct  out  6  id_instr[5:0].
- id_rt  out  5  id_instr[20:16].

Behaviour:
- Reset values: pc=RESET_PC, state=IDLE, imem_req=0, id_valid=0, id_instr=0, id_pc=0, id_pc_plus4=0, hold buffer=0.
- Redirect target, with priority r_jump > jump > branch_taken:
  - r_jump: jr_target.
  - jump: {id_pc_plus4[31:28], id_instr[25:0], 2'b00}.
  - branch_taken: id_pc_plus4 + (sign-extended id_instr[15:0] << 2), mod 2^32.
  - Target bits [1:0] are forced to 0.
- Redirect inputs are sampled only when stall=0 and id_valid=1. Otherwise they are ignored, and ID must hold them until stall drops.
- States:
  - IDLE: one cycle after reset, then REQ.
  - REQ: imem_req=1, imem_addr=pc. On imem_ready, go to WAIT.
  - WAIT: on imem_rvalid with stall=0: IF/ID <= {rdata, pc, pc+4}, id_valid=1, pc <= pc+4, go to REQ. On imem_rvalid with stall=1: capture rdata in the hold buffer, go to HOLD.
  - HOLD: imem_req=0. When stall=0, load IF/ID from the hold buffer, pc <= pc+4, go to REQ.
  - DROP: wait for imem_rvalid, discard the word, go to REQ. imem_req=0 in DROP.
- Redirect accepted in any cycle: pc <= target, and id_valid <= 0 unless a fetch completes that same cycle. In that case the completed word is discarded and id_valid <= 0.
- Redirect state transitions:
  - In REQ without imem_ready: stay in REQ; the address changes next cycle.
  - In REQ with imem_ready the same cycle: go to DROP.
  - In WAIT without rvalid: go to DROP.
  - In WAIT with rvalid: discard, go to REQ.
  - In HOLD: discard the buffer, go to REQ.
- stall=1 and no redirect: IF/ID outputs hold their values. The pending memory transaction still completes into the hold buffer.
- Request latency: when the memory responds the cycle after acceptance, throughput is one instruction per 2 cycles (REQ, WAIT).
- PC wraps modulo 2^32 (0xFFFF_FFFC + 4 = 0).
- Reset asserted mid-transaction returns everything to reset values immediately. Any later stray rvalid while in IDLE or REQ is ignored.

Optional Feature:
- FETCH_PERF_CNT_EN defined: adds outputs perf_fetched (32) and perf_squashed (32). Both reset to 0 and wrap modulo 2^32.
  - perf_fetched increments on each word loaded into IF/ID.
  - perf_squashed increments on each fetched word discarded by a redirect: WAIT+rvalid redirect, DROP completion, or HOLD redirect.
- Not defined: the ports and counters are absent. Core behaviour is identical either way.

Test Plan:
- Reset release, memory responding 1 cycle after ready, data 0x8C080004 then 0x00000000 -> imem_addr 0x00400000 then 0x00400004; id_instr=0x8C080004 with id_pc=0x00400000, id_pc_plus4=0x00400004, id_opcode=0x23, id_rt=8.
- id_instr=0x08100010 (j) at id_pc 0x00400008, jump=1 -> next imem_addr 0x00400040; younger word squashed; id_valid=0 for one fetch; id_instr reads 0.
- Branch at id_pc 0x00400010 with imm 0xFFFC, branch_taken=1, redirect while in WAIT without rvalid -> DROP discards the late word; next imem_addr 0x00400004.
- Redirect asserted together with r_jump, jump and branch_taken, jr_target=0x00400123 -> imem_addr 0x00400120 (r_jump wins, low bits cleared).
- stall=1 for 5 cycles while rvalid arrives with 0x20090005 -> id outputs unchanged during stall; word released to id_instr the cycle after stall drops; no lost or duplicate PC.
- rst_n asserted while in WAIT, then rvalid pulses -> outputs at reset values, pulse ignored, fetch restarts at 0x00400000. With FETCH_PERF_CNT_EN: counters read 0.
